// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a pending-destination mask for decode interlock and a starvation guard.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            lu_valid,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            lu_ready,
  output logic            stall_req,
  output logic [31:0]     pend_mask,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic empty, full, push, pop, wb_ok, grant_wb;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign lu_ready  = !full;
  assign stall_req = !empty && (starve_q == SW'(STARVE_LIMIT));

  // Pipeline wins unless the head has starved; otherwise any queued head drains.
  assign wb_ok    = wb_valid && wb_we && (wb_rd != 5'd0);
  assign grant_wb = wb_ok && !stall_req;
  assign pop      = !empty && !grant_wb;
  assign push     = lu_valid && !full && (lu_rd != 5'd0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    starve_d   = starve_q;
    rf_we_d    = grant_wb || pop;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    if (empty || pop)                          starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))    starve_d = starve_q + SW'(1);

    if (grant_wb) begin
      rf_rd_d    = wb_rd;
      rf_wdata_d = wb_data;
    end else if (pop) begin
      rf_rd_d    = rd_mem[rd_ptr_q];
      rf_wdata_d = data_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]   <= lu_rd;
      data_mem[wr_ptr_q] <= lu_data;
    end
  end

  logic [FIFO_DEPTH-1:0] ent_valid;
  logic [PW-1:0]         ent_off  [FIFO_DEPTH];
  logic [31:0]           ent_mask [FIFO_DEPTH];

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_ent
      assign ent_off[gi]   = PW'(gi) - rd_ptr_q;
      assign ent_valid[gi] = ({1'b0, ent_off[gi]} < count_q);
      assign ent_mask[gi]  = ent_valid[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) pend_mask = pend_mask | ent_mask[i];
    pend_mask[0] = 1'b0;
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wb_valid, wb_we, lu_valid;
  logic [4:0]      wb_rd, lu_rd;
  logic [XLEN-1:0] wb_data, lu_data;
  logic            lu_ready, stall_req, rf_we;
  logic [31:0]     pend_mask;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .stall_req(stall_req), .pend_mask(pend_mask),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            mq[$];
  int              starve_m;
  logic            exp_we;
  logic [4:0]      exp_rd;
  logic [XLEN-1:0] exp_data;
  logic [4:0]      wr_log[$];
  logic            obs_stall, obs_ready;
  int              tests = 0;
  int              fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic we, input logic [4:0] wrd, input logic [63:0] wd,
                       input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
    wb_valid = wv; wb_we = we; wb_rd = wrd; wb_data = wd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at the edge,
  // then check the registered write port just after the edge.
  task automatic tick(input string tag);
    logic [31:0] m;
    bit full_m, stall_m, had, wb_ok, pop_m;
    @(negedge clk);
    m = 32'd0;
    foreach (mq[i]) m = m | (32'd1 << mq[i].rd);
    full_m  = (mq.size() >= DEPTH);
    stall_m = (mq.size() > 0) && (starve_m == LIMIT);
    chk($sformatf("%s.lu_ready", tag), lu_ready, !full_m);
    chk($sformatf("%s.stall_req", tag), stall_req, stall_m);
    chk($sformatf("%s.pend_mask", tag), pend_mask, m);
    obs_stall = stall_req;
    obs_ready = lu_ready;
    @(posedge clk);
    wb_ok = wb_valid && wb_we && (wb_rd != 0);
    had   = (mq.size() > 0);
    pop_m = had && (stall_m || !wb_ok);
    if (!stall_m && wb_ok) begin
      exp_we = 1'b1; exp_rd = wb_rd; exp_data = wb_data;
    end else if (pop_m) begin
      exp_we = 1'b1; exp_rd = mq[0].rd; exp_data = mq[0].data;
    end else begin
      exp_we = 1'b0;
    end
    if (!had || pop_m) starve_m = 0;
    else if (starve_m < LIMIT) starve_m = starve_m + 1;
    if (pop_m) void'(mq.pop_front());
    if (lu_valid && !full_m && lu_rd != 0) mq.push_back('{rd: lu_rd, data: lu_data});
    #1;
    chk($sformatf("%s.rf_we", tag), rf_we, exp_we);
    chk($sformatf("%s.rf_rd", tag), rf_rd, exp_rd);
    chk($sformatf("%s.rf_wdata", tag), rf_wdata, exp_data);
    if (rf_we) wr_log.push_back(rf_rd);
  endtask

  task automatic model_reset();
    mq.delete();
    starve_m = 0;
    exp_we = 1'b0; exp_rd = '0; exp_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst.rf_we", rf_we, 1'b0);
    chk("rst.rf_rd", rf_rd, 5'd0);
    chk("rst.rf_wdata", rf_wdata, 64'd0);
    chk("rst.lu_ready", lu_ready, 1'b1);
    chk("rst.stall_req", stall_req, 1'b0);
    chk("rst.pend_mask", pend_mask, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int k;
    logic [4:0] order[$];

    do_reset();

    // Pipeline write appears one cycle later, then drops.
    drive(1, 1, 5, 64'h1234, 0, 0, 0);
    tick("t1a");
    chk("t1.rf_we", rf_we, 1'b1);
    chk("t1.rf_rd", rf_rd, 5'd5);
    chk("t1.rf_wdata", rf_wdata, 64'h1234);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("t1b");
    chk("t1.rf_we_drop", rf_we, 1'b0);
    $display("[TB] test1 pipeline write done");

    // Lone long-latency result: mask next cycle, write the cycle after.
    drive(0, 0, 0, 0, 1, 7, 64'hDEAD);
    tick("t2a");
    chk("t2.pend_mask_n1", pend_mask, 32'h80);
    chk("t2.rf_we_n1", rf_we, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("t2b");
    chk("t2.rf_we_n2", rf_we, 1'b1);
    chk("t2.rf_rd_n2", rf_rd, 5'd7);
    chk("t2.rf_wdata_n2", rf_wdata, 64'hDEAD);
    chk("t2.pend_mask_n2", pend_mask, 32'd0);
    $display("[TB] test2 lone lu result done");

    // Starvation: two buffered results behind a busy pipeline.
    do_reset();
    drive(1, 1, 10, 64'h10, 1, 3, 64'h333);
    tick("t3a");
    drive(1, 1, 11, 64'h11, 1, 4, 64'h444);
    tick("t3b");
    chk("t3.lu_ready_full", lu_ready, 1'b0);
    drive(1, 1, 12, 64'h12, 0, 0, 0);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick("t3c");
      if (obs_stall) begin k = i; break; end
    end
    // rd=3 was already denied during the second enqueue cycle.
    chk("t3.first_stall_cycle", k, 4);
    chk("t3.first_stall_rd", rf_rd, 5'd3);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick("t3d");
      if (obs_stall) begin k = i; break; end
    end
    // Four denied cycles for rd=4, then the stall.
    chk("t3.second_stall_cycle", k, LIMIT + 1);
    chk("t3.second_stall_rd", rf_rd, 5'd4);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick("t3e");
    $display("[TB] test3 starvation done");

    // x0 destinations never buffer nor write.
    drive(1, 1, 0, 64'hBAD, 1, 0, 64'hBAD);
    for (int i = 0; i < 3; i++) begin
      tick("t4");
      chk("t4.rf_we", rf_we, 1'b0);
      chk("t4.pend_mask", pend_mask, 32'd0);
    end
    $display("[TB] test4 x0 writes done");

    // Full FIFO holds off a third result until the cycle after the first dequeue.
    do_reset();
    wr_log.delete();
    drive(1, 1, 20, 64'h20, 1, 9, 64'h999);
    tick("t5a");
    drive(1, 1, 20, 64'h20, 1, 10, 64'hAAA);
    tick("t5b");
    drive(1, 1, 20, 64'h20, 1, 11, 64'hBBB);
    tick("t5c");
    chk("t5.held_while_full", obs_ready, 1'b0);
    drive(0, 0, 0, 0, 1, 11, 64'hBBB);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      tick("t5d");
      if (obs_ready) begin k = i; break; end
    end
    chk("t5.capture_cycle", k, 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick("t5e");
    foreach (wr_log[i]) if (wr_log[i] != 5'd20) order.push_back(wr_log[i]);
    chk("t5.drain_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("t5.order0", order[0], 5'd9);
      chk("t5.order1", order[1], 5'd10);
      chk("t5.order2", order[2], 5'd11);
    end
    $display("[TB] test5 full fifo ordering done");

    // Asynchronous reset mid-cycle with two entries and a write in flight.
    drive(1, 1, 21, 64'h21, 1, 3, 64'h3);
    tick("t6a");
    drive(1, 1, 22, 64'h22, 1, 4, 64'h4);
    tick("t6b");
    #1;
    chk("t6.pre_rf_we", rf_we, 1'b1);
    chk("t6.pre_pend_mask", pend_mask, 32'h18);
    #1 rst_n = 1'b0;
    #1;
    chk("t6.rf_we", rf_we, 1'b0);
    chk("t6.pend_mask", pend_mask, 32'd0);
    chk("t6.lu_ready", lu_ready, 1'b1);
    chk("t6.stall_req", stall_req, 1'b0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    $display("[TB] test6 async reset done");

    // Random traffic; small rd range forces duplicates and x0 cases.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
            {$urandom, $urandom}, $urandom_range(0, 1), 5'($urandom_range(0, 7)),
            {$urandom, $urandom});
      tick("rnd");
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stage and one long-latency unit (divider / late load return).
- The pipeline WB result is already selected (alu/mem/npc) before it reaches this block.
- Long-latency results are buffered in a small FIFO and exposed as a pending-destination mask, so decode can interlock.
- A starvation guard stalls the pipeline WB stage when a buffered result has waited too long.

Parameters:
XLEN, 64, datapath width.
FIFO_DEPTH, 2, long-latency result buffer entries; power of two, >= 2.
STARVE_LIMIT, 4, consecutive denied cycles before stall_req asserts; >= 1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
wb_valid  in  1  pipeline WB stage holds an instruction this cycle.
wb_we  in  1  that instruction writes rd.
wb_rd  in  5  pipeline destination register.
wb_data  in  XLEN  pipeline writeback data.
lu_valid  in  1  long-latency unit presents a result.
lu_rd  in  5  long-latency destination register.
lu_data  in  XLEN  long-latency result.
lu_ready  out  1  FIFO can accept; equals !full.
stall_req  out  1  pipeline must hold its WB instruction this cycle.
pend_mask  out  32  bit i set if a valid FIFO entry targets xi.
rf_we  out  1  register-file write enable.
rf_rd  out  5  register-file write address.
rf_wdata  out  XLEN  register-file write data.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0, starve_cnt 0, rf_we 0, rf_rd 0, rf_wdata 0. Outputs then read lu_ready 1, stall_req 0, pend_mask 0.
- Enqueue: when lu_valid && lu_ready at a clock edge, the entry is written. If lu_rd==0, the result is accepted and discarded (no entry, no mask bit). If lu_valid && !lu_ready, nothing is captured; the unit holds its result.
- Head eligibility: the head entry is eligible the cycle after it is enqueued. There is no same-cycle bypass.
- Grant, combinational each cycle:
  - stall_req = FIFO non-empty && (starve_cnt == STARVE_LIMIT).
  - If stall_req=1: grant the FIFO head and ignore the pipeline. The pipeline must present the same wb_* next cycle.
  - Else if wb_valid && wb_we && wb_rd != 0: grant the pipeline.
  - Else if FIFO non-empty: grant the head.
  - Else: no grant.
- Write-port output is registered with 1-cycle latency. At the edge after a grant: rf_we=1 and rf_rd/rf_wdata take the granted source. With no grant: rf_we=0 and rf_rd/rf_wdata hold their previous values.
- Writes with rd=0 never raise rf_we.
- Dequeue: the head is popped at the edge where it is granted.
- Simultaneous push and pop with FIFO full:
  - Not allowed, because lu_ready is computed from current occupancy.
  - A pop frees the slot only from the next cycle.
- Simultaneous push and pop with FIFO non-full: both occur; occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Full and empty are distinguished by a count (or an extra pointer bit).
- starve_cnt:
  - Reset to 0 when the FIFO is empty or the head is granted.
  - Otherwise increments each cycle, saturating at STARVE_LIMIT.
- pend_mask: combinational OR of one-hot(rd) over valid entries; bit 0 is always 0. Duplicate rd entries both keep the bit set until both drain.
- Ordering:
  - The arbiter performs no WAW checks.
  - Decode must stall any instruction whose rd or rs hits pend_mask.
  - FIFO order is preserved.
- Reset mid-operation: FIFO contents are dropped, and in-flight rf_we is cleared immediately (async).

Test Plan:
1. Reset, then wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234 for one cycle -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234; the cycle after, rf_we=0.
2. FIFO empty, lu_valid=1, lu_rd=7, lu_data=0xDEAD at cycle N, no pipeline writes -> pend_mask=0x80 from N+1; rf_we=1, rf_rd=7 at N+2; pend_mask=0 at N+2.
3. Two LU results (rd=3, rd=4) while the pipeline writes every cycle -> lu_ready=0 after two enqueues; after STARVE_LIMIT=4 denied cycles stall_req=1 for one cycle; rf_rd=3 the next cycle; stall_req re-asserts 4 cycles later for rd=4.
4. lu_rd=0 with lu_valid=1, and wb_rd=0 with wb_we=1 -> no FIFO entry, pend_mask=0, rf_we never 1.
5. FIFO full (DEPTH=2), lu_valid held high with a third result -> not captured until the cycle after the first dequeue; order out is rd A, B, C.
6. Assert rst_n=0 mid-cycle with 2 entries and rf_we=1 -> rf_we, pend_mask and starve_cnt immediately 0; lu_ready=1 without waiting for a clock edge.
